// File: rtl/aq_gemac_ping_tx_pkg.sv
// Shared GEMAC definitions (ethertype, IP/ICMP constants) plus the ping
// transmitter's state type and one's-complement helpers.
package aq_gemac_ping_tx_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL        = 8'h45;
  localparam logic [7:0]  IP_PROTO_ICMP     = 8'd1;
  localparam logic [7:0]  ICMP_ECHO_REQUEST = 8'd8;
  localparam logic [7:0]  ICMP_CODE         = 8'd0;

  localparam int HDR_WORDS = 11;
  localparam int IDX_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_WAIT,
    ST_SEND,
    ST_GAP
  } state_t;

  // 17-bit add with the carry wrapped back into bit 0.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [15:0] ip_hdr_csum(input logic [15:0] total_len,
                                              input logic [15:0] ip_id,
                                              input logic [7:0]  ttl,
                                              input logic [31:0] src,
                                              input logic [31:0] dst);
    logic [15:0] acc;
    acc = {IP_VER_IHL, 8'h00};
    acc = oc_add(acc, total_len);
    acc = oc_add(acc, ip_id);
    acc = oc_add(acc, 16'h4000);
    acc = oc_add(acc, {ttl, IP_PROTO_ICMP});
    acc = oc_add(acc, {src[7:0], src[15:8]});
    acc = oc_add(acc, {src[23:16], src[31:24]});
    acc = oc_add(acc, {dst[7:0], dst[15:8]});
    acc = oc_add(acc, {dst[23:16], dst[31:24]});
    return ~acc;
  endfunction

endpackage

// File: rtl/aq_gemac_ping_tx_csum16.sv
// Internet checksum accumulator: clear, add one 32-bit word (two 16-bit
// big-endian pairs) per cycle, complemented result always available.
module aq_gemac_csum16
  import aq_gemac_ping_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add_en,
  input  logic [31:0] word,
  output logic [15:0] csum
);

  logic [15:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 16'h0000;
    end else if (add_en) begin
      acc_d = oc_add(oc_add(acc_q, word[31:16]), word[15:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 16'h0000;
    else        acc_q <= acc_d;
  end

  assign csum = ~acc_q;

endmodule

// File: rtl/aq_gemac_ping_tx.sv
// Periodic ICMP echo-request generator writing whole Ethernet frames, one
// 32-bit little-endian-packed word per cycle, into the GEMAC TX buffer.
module aq_gemac_ping_tx
  import aq_gemac_ping_tx_pkg::*;
#(
  parameter logic [15:0] ICMP_ID       = 16'h0001,
  parameter int          PAYLOAD_WORDS = 14,
  parameter logic [7:0]  TTL           = 8'd64
) (
  input  logic         CLK125M,
  input  logic         RST_N,
  input  logic         ENABLE,
  input  logic [31:0]  INTERVAL,
  input  logic         ARPC_VALID,
  input  logic [47:0]  MY_MAC_ADDRESS,
  input  logic [47:0]  PEER_MAC_ADDRESS,
  input  logic [31:0]  MY_IP_ADDRESS,
  input  logic [31:0]  PEER_IP_ADDRESS,
  input  logic         TX_BUFF_READY,
  input  logic         TX_BUFF_FULL,
  input  logic [9:0]   TX_BUFF_SPACE,
  output logic         TX_BUFF_WE,
  output logic         TX_BUFF_START,
  output logic         TX_BUFF_END,
  output logic [31:0]  TX_BUFF_DATA,
  output logic [15:0]  SEQ_NO,
  output logic [31:0]  SENT_COUNT,
  output logic         BUSY,
  output state_t       DBG_STATE
);

  localparam int               FRAME_WORDS = HDR_WORDS + PAYLOAD_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0] CSUM_LAST   = IDX_W'(PAYLOAD_WORDS + 1);
  localparam logic [9:0]       SPACE_NEED  = 10'(FRAME_WORDS);
  localparam logic [15:0]      IP_LEN      = 16'(30 + 4 * PAYLOAD_WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      seq_q, seq_d;
  logic [31:0]      gap_q, gap_d;
  logic             we_q, we_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic [31:0]      data_q, data_d;
  logic [15:0]      seq_no_q, seq_no_d;
  logic [31:0]      sent_q, sent_d;
  logic             busy_q, busy_d;

  logic [31:0] csum_word;
  logic [7:0]  csum_pb;
  logic [15:0] icmp_csum;
  logic [15:0] ip_csum;
  logic [31:0] frame_word;
  logic [7:0]  frame_pb;

  // Cycle 0: type/code + id; cycle 1: sequence + payload bytes 0,1;
  // later cycles: four consecutive payload bytes starting at 4*idx-6.
  always_comb begin
    csum_pb = {idx_q[5:0], 2'b00} - 8'd6;
    case (idx_q)
      9'd0:    csum_word = {ICMP_ECHO_REQUEST, ICMP_CODE, ICMP_ID};
      9'd1:    csum_word = {seq_q, 16'h0001};
      default: csum_word = {csum_pb, csum_pb + 8'd1, csum_pb + 8'd2, csum_pb + 8'd3};
    endcase
  end

  aq_gemac_csum16 u_icmp_csum (
    .clk    (CLK125M),
    .rst_n  (RST_N),
    .clr    (state_q == ST_IDLE),
    .add_en (state_q == ST_CSUM),
    .word   (csum_word),
    .csum   (icmp_csum)
  );

  // Depends only on the held sequence and static addresses, so it is settled
  // long before the IP header words are muxed out.
  assign ip_csum = ip_hdr_csum(IP_LEN, seq_q, TTL, MY_IP_ADDRESS, PEER_IP_ADDRESS);

  always_comb begin
    frame_pb = {idx_q[5:0], 2'b00} - 8'd42;
    case (idx_q)
      9'd0:    frame_word = PEER_MAC_ADDRESS[31:0];
      9'd1:    frame_word = {MY_MAC_ADDRESS[15:0], PEER_MAC_ADDRESS[47:32]};
      9'd2:    frame_word = MY_MAC_ADDRESS[47:16];
      9'd3:    frame_word = {8'h00, IP_VER_IHL, ETHERTYPE_IPV4[7:0], ETHERTYPE_IPV4[15:8]};
      9'd4:    frame_word = {seq_q[7:0], seq_q[15:8], IP_LEN[7:0], IP_LEN[15:8]};
      9'd5:    frame_word = {IP_PROTO_ICMP, TTL, 8'h00, 8'h40};
      9'd6:    frame_word = {MY_IP_ADDRESS[15:0], ip_csum[7:0], ip_csum[15:8]};
      9'd7:    frame_word = {PEER_IP_ADDRESS[15:0], MY_IP_ADDRESS[31:16]};
      9'd8:    frame_word = {ICMP_CODE, ICMP_ECHO_REQUEST, PEER_IP_ADDRESS[31:16]};
      9'd9:    frame_word = {ICMP_ID[7:0], ICMP_ID[15:8], icmp_csum[7:0], icmp_csum[15:8]};
      9'd10:   frame_word = {8'h01, 8'h00, seq_q[7:0], seq_q[15:8]};
      default: frame_word = {frame_pb + 8'd3, frame_pb + 8'd2, frame_pb + 8'd1, frame_pb};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    gap_d    = gap_q;
    we_d     = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    data_d   = data_q;
    seq_no_d = seq_no_q;
    sent_d   = sent_q;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE && ARPC_VALID) begin
          state_d = ST_CSUM;
          idx_d   = '0;
        end
      end
      ST_CSUM: begin
        if (idx_q == CSUM_LAST) begin
          state_d = ST_WAIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (TX_BUFF_READY && (TX_BUFF_SPACE >= SPACE_NEED)) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (!TX_BUFF_FULL) begin
          we_d    = 1'b1;
          data_d  = frame_word;
          start_d = (idx_q == '0);
          end_d   = (idx_q == LAST_IDX);
          if (idx_q == LAST_IDX) begin
            state_d  = ST_GAP;
            gap_d    = INTERVAL;
            seq_no_d = seq_q;
            seq_d    = seq_q + 16'd1;
            sent_d   = sent_q + 32'd1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 32'd0) state_d = ST_IDLE;
        else                gap_d   = gap_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CSUM) || (state_d == ST_WAIT) || (state_d == ST_SEND);
  end

  // RST_N arrives already release-synchronised from the top level.
  always_ff @(posedge CLK125M or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      seq_q    <= 16'h0000;
      gap_q    <= 32'd0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      data_q   <= 32'd0;
      seq_no_q <= 16'h0000;
      sent_q   <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      gap_q    <= gap_d;
      we_q     <= we_d;
      start_q  <= start_d;
      end_q    <= end_d;
      data_q   <= data_d;
      seq_no_q <= seq_no_d;
      sent_q   <= sent_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_BUFF_WE    = we_q;
  assign TX_BUFF_START = start_q;
  assign TX_BUFF_END   = end_q;
  assign TX_BUFF_DATA  = data_q;
  assign SEQ_NO        = seq_no_q;
  assign SENT_COUNT    = sent_q;
  assign BUSY          = busy_q;
  assign DBG_STATE     = state_q;

endmodule

// File: doc/aq_gemac_ping_tx.md
AQ_GEMAC_PING_TX -- requirements
Module: aq_gemac_ping_tx

Interface
REQ-001 SHALL have parameter ICMP_ID, default 16'h0001, ICMP identifier field.
REQ-002 SHALL have parameter PAYLOAD_WORDS, default 14, legal 4..256; ICMP payload = 4*PAYLOAD_WORDS+2 bytes; frame = 11+PAYLOAD_WORDS 32-bit words.
REQ-003 SHALL have parameter TTL, default 8'd64, IP time-to-live.
REQ-004 Ports, clock and reset first; reset is RST_N, asynchronous, active-low; clock is CLK125M:
  CLK125M  in  1  system clock, all logic on rising edge
  RST_N  in  1  asynchronous active-low reset
  ENABLE  in  1  periodic echo-request generation enable
  INTERVAL  in  32  idle cycles between END of one frame and start of next
  ARPC_VALID  in  1  peer MAC resolved; no frame sent while 0
  MY_MAC_ADDRESS  in  48  source MAC, first-sent byte in [7:0]
  PEER_MAC_ADDRESS  in  48  destination MAC, first-sent byte in [7:0]
  MY_IP_ADDRESS  in  32  source IP, first-sent byte in [7:0]
  PEER_IP_ADDRESS  in  32  destination IP, first-sent byte in [7:0]
  TX_BUFF_READY  in  1  MAC TX buffer can accept a new frame
  TX_BUFF_FULL  in  1  MAC TX buffer cannot accept a word this cycle
  TX_BUFF_SPACE  in  10  free words in MAC TX buffer
  TX_BUFF_WE  out  1  word write strobe
  TX_BUFF_START  out  1  with WE, first word of frame
  TX_BUFF_END  out  1  with WE, last word of frame
  TX_BUFF_DATA  out  32  frame word; byte 4n of frame in [7:0], 4n+3 in [31:24]
  SEQ_NO  out  16  sequence number of the last frame fully written
  SENT_COUNT  out  32  frames fully written since reset
  BUSY  out  1  state is not IDLE/GAP

Function
REQ-005 States: IDLE, CSUM, WAIT, SEND, GAP.
REQ-006 IDLE -> CSUM when ENABLE=1 and ARPC_VALID=1; otherwise remain.
REQ-007 CSUM: accumulate ICMP checksum over header (type/code 0x0800, ICMP_ID, next sequence) and payload, one 32-bit payload word per cycle, 17-bit end-around-carry adds; final fold and one's complement; exactly PAYLOAD_WORDS+2 cycles; then -> WAIT.
REQ-008 IP header checksum SHALL be computed by the same accumulator in parallel, or combinationally, and be stable before WAIT exits.
REQ-009 WAIT -> SEND when TX_BUFF_READY=1 and TX_BUFF_SPACE >= 11+PAYLOAD_WORDS; ENABLE dropping in WAIT -> IDLE without writing.
REQ-010 SEND: one word per cycle with TX_BUFF_WE=1 while TX_BUFF_FULL=0; when FULL=1, WE=0 and word index and data held; START only on word 0, END only on last word.
REQ-011 Frame bytes: 0-5 PEER_MAC; 6-11 MY_MAC; 12-13 0x08,0x00; IP: 0x45, 0x00, total length 30+4*PAYLOAD_WORDS (big-endian), IP ID = sequence, 0x40,0x00, TTL, 0x01, header checksum, MY_IP, PEER_IP; ICMP: 0x08, 0x00, checksum, ICMP_ID, sequence (big-endian); payload byte k = k mod 256.
REQ-012 Checksums SHALL use 16-bit big-endian pairs (byte 2i in bits [15:8]).
REQ-013 After END written: SEQ_NO <= sequence, SENT_COUNT += 1 (wraps at 2^32), next sequence = sequence+1 (wraps 16'hFFFF -> 0); -> GAP.
REQ-014 GAP: counter loads INTERVAL, decrements each cycle; at 0 -> IDLE; INTERVAL=0 gives one GAP cycle.
REQ-015 ENABLE or ARPC_VALID deasserted during CSUM/SEND SHALL NOT abort; frame completes.
REQ-016 Sequence of first frame after reset is 16'h0000.

Reset
REQ-017 RST_N low SHALL immediately force state IDLE, WE/START/END=0, DATA=0, SEQ_NO=0, SENT_COUNT=0, BUSY=0, sequence 0, GAP counter 0, including mid-frame (partial frame abandoned).
REQ-018 Release SHALL be synchronised to CLK125M by the top level; block uses RST_N directly.

Structure
REQ-019 Shared include file aq_gemac_defs: ethertype 0x0800, IP proto ICMP 1, ICMP type 8/0, version/IHL 0x45.
REQ-020 Sub-module aq_gemac_csum16: clear, add 32-bit word, fold/complement result; reusable by future UDP TX.
REQ-021 Word mux in SEND SHALL be a registered case on word index; no RAM.

Verification
REQ-022 PAYLOAD_WORDS=4, INTERVAL=100, ENABLE=1, ARPC_VALID=1, READY=1, SPACE=512 -> 15 WE pulses, START on word 0, END on word 14, word 3 = 32'h00450008, IP total length 46.
REQ-023 Same, MY_IP=32'h960DA8C0, PEER_IP=32'h960DA8C1 -> IP and ICMP checksums match software model; receiver sum over header/ICMP = 16'hFFFF.
REQ-024 TX_BUFF_FULL=1 for 3 cycles at word 5 -> no WE those cycles, word 5 data held, frame still 15 words, identical content.
REQ-025 Two frames with INTERVAL=0 -> second IP ID/ICMP seq = 1, SENT_COUNT=2, SEQ_NO=1; SPACE=14 -> block waits in WAIT, no WE.
REQ-026 RST_N low at word 7 -> WE=0 same cycle, SENT_COUNT=0; after release next frame starts at seq 0 with START.
